mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL use these ports, one per line as name, direction, width, meaning, with clock and reset first:
- clk  in  1  clock; rising edge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- mem_waddr  in  5  destination register from the EX/MEM register.
- mem_we  in  1  register-write enable from EX/MEM.
- mem_wdata  in  32  ALU result from EX/MEM.
- mem_mem_addr  in  32  effective byte address.
- mem_mem_aluop  in  8  operation; EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from defines.v are memory ops, all others are non-memory.
- mem_rt_data  in  32  store source data.
- out_waddr  out  5  to MEM/WB.
- out_we  out  1  to MEM/WB.
- out_wdata  out  32  to MEM/WB.
- stallreq_mem  out  1  stall request to the pipeline controller.
- dbus_req  out  1  bus request.
- dbus_we  out  1  bus write (1 = store).
- dbus_addr  out  32  word-aligned address.
- dbus_sel  out  4  byte-lane enables; bit n is byte n (little-endian).
- dbus_wdata  out  32  store data.
- dbus_rdata  in  32  load data; valid with dbus_ack.
- dbus_ack  in  1  single-cycle completion strobe.
- misalign_exc  out  1  misaligned-access flag.

Function
REQ-002 The block SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-003 The FSM SHALL take these transitions:
- IDLE with a memory op and dbus_ack=0 -> WAIT.
- IDLE with a memory op and dbus_ack=1 -> DONE.
- WAIT with dbus_ack=1 -> DONE.
- DONE -> IDLE unconditionally.
REQ-004 The block SHALL drive stallreq_mem = dbus_req = (IDLE and memory op) or WAIT; neither SHALL depend on dbus_ack combinationally.
REQ-005 The block SHALL form dbus_addr = {mem_mem_addr[31:2], 2'b00} and dbus_we = 1 only for SB/SH/SW; dbus_* SHALL be combinational from the inputs, which are stable while stalled.
REQ-006 Byte lanes SHALL be:
- Byte ops: sel = 1 << addr[1:0].
- Half ops: sel = 4'b0011 when addr[1]=0, else 4'b1100.
- Word ops: sel = 4'b1111.
REQ-007 Store data SHALL be {4{rt[7:0]}} for SB, {2{rt[15:0]}} for SH and rt for SW.
REQ-008 On dbus_ack for a load, the block SHALL extract the addressed byte or half from dbus_rdata, apply sign extension for LB/LH and zero extension for LBU/LHU, and register the result in rdata_q.
REQ-009 In DONE the block SHALL drive out_wdata = rdata_q for loads and mem_wdata for stores, out_we = mem_we and out_waddr = mem_waddr.
REQ-010 For a non-memory op in IDLE, out_* SHALL pass mem_* through combinationally, with zero added latency.
REQ-011 out_we SHALL be 0 whenever stallreq_mem = 1.
REQ-012 dbus_ack SHALL be ignored in DONE, and in IDLE when no memory op is present.
REQ-013 The minimum load/store cost SHALL be one stall cycle (zero-wait ack); each additional bus wait cycle SHALL add one stall cycle.
REQ-014 The DONE state SHALL guarantee that the held instruction is never re-issued; the next IDLE cycle SHALL see the next instruction.

Reset
REQ-015 On rst=1 at a clock edge, the state SHALL become IDLE and rdata_q SHALL become 0, including a reset taken mid-WAIT; an ack arriving after reset SHALL be ignored.
REQ-016 While rst=1, the combinational outputs SHALL follow the IDLE equations, with misalign_exc = 0.

Configuration
REQ-017 With LSU_MISALIGN_TRAP_EN defined, a half op with addr[0]=1 or a word op with addr[1:0] != 0 SHALL produce misalign_exc = 1 in that cycle, dbus_req = 0, stallreq_mem = 0 and out_we = 0, and the FSM SHALL stay in IDLE.
REQ-018 Without LSU_MISALIGN_TRAP_EN, the misaligned low address bits SHALL be ignored (half ops use addr[1] only; word ops use sel = 1111), and misalign_exc SHALL be tied to 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LW, addr 0x100, ack in the same cycle as req, rdata 0xDEADBEEF -> one stall cycle; DONE gives out_wdata 0xDEADBEEF, out_we 1.
- LB, addr 0x103, rdata 0x80FFFFFF, ack after 3 wait cycles -> sel 1000, stall for 4 cycles, out_wdata 0xFFFFFF80; the same access with LBU -> 0x00000080.
- SH, addr 0x202, rt 0x1234ABCD -> dbus_we 1, sel 1100, wdata 0xABCDABCD, out_we 0.
- ADD op, mem_wdata 0x5 -> no req, no stall, out_wdata 0x5 in the same cycle.
- rst asserted during WAIT, then a late ack -> IDLE, rdata_q 0, no writeback.
- LW, addr 0x101 -> with LSU_MISALIGN_TRAP_EN: misalign_exc 1, no req; without it: req with addr 0x100, sel 1111.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: stalls the pipeline across one data-bus access per memory op.
// Optional build macro LSU_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of issuing them.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_mem_addr,
    input  logic [7:0]  mem_mem_aluop,
    input  logic [31:0] mem_rt_data,
    output logic [4:0]  out_waddr,
    output logic        out_we,
    output logic [31:0] out_wdata,
    output logic        stallreq_mem,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        misalign_exc
);
    // state | meaning
    // IDLE  | no access in flight; non-memory ops pass straight through
    // WAIT  | request issued, waiting for dbus_ack
    // DONE  | access finished, writeback presented for one cycle, stall released

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d, state_cur;
    logic        is_load, is_store, is_byte, is_half, is_word, is_unsigned;
    logic        mem_op, misalign, mem_go, busy;
    logic [31:0] rdata_q, load_ext;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        case (mem_mem_aluop)
            EXE_LB_OP:  begin is_load = 1'b1;  is_byte = 1'b1; end
            EXE_LBU_OP: begin is_load = 1'b1;  is_byte = 1'b1; is_unsigned = 1'b1; end
            EXE_LH_OP:  begin is_load = 1'b1;  is_half = 1'b1; end
            EXE_LHU_OP: begin is_load = 1'b1;  is_half = 1'b1; is_unsigned = 1'b1; end
            EXE_LW_OP:  begin is_load = 1'b1;  is_word = 1'b1; end
            EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
            EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
            EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign mem_op = is_load | is_store;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = mem_op & ((is_half & mem_mem_addr[0]) | (is_word & (|mem_mem_addr[1:0])));
`else
    assign misalign = 1'b0;
`endif

    assign misalign_exc = misalign & ~rst;
    assign mem_go       = mem_op & ~misalign;

    // Reset forces the IDLE view combinationally so a late ack cannot leak through.
    assign state_cur = rst ? IDLE : state_q;
    assign busy      = ((state_cur == IDLE) & mem_go) | (state_cur == WAIT);

    always_comb begin
        state_d = state_cur;
        case (state_cur)
            IDLE:    if (mem_go) state_d = dbus_ack ? DONE : WAIT;
            WAIT:    if (dbus_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (mem_mem_addr[1:0])
            2'd0:    load_byte = dbus_rdata[7:0];
            2'd1:    load_byte = dbus_rdata[15:8];
            2'd2:    load_byte = dbus_rdata[23:16];
            default: load_byte = dbus_rdata[31:24];
        endcase
        load_half = mem_mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        load_ext  = dbus_rdata;
        if (is_byte)
            load_ext = is_unsigned ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
        else if (is_half)
            load_ext = is_unsigned ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (busy && dbus_ack && is_load)
                rdata_q <= load_ext;
        end
    end

    always_comb begin
        dbus_req   = busy;
        dbus_we    = is_store;
        dbus_addr  = {mem_mem_addr[31:2], 2'b00};
        dbus_sel   = 4'b0000;
        dbus_wdata = mem_rt_data;
        if (is_byte) begin
            dbus_sel   = 4'b0001 << mem_mem_addr[1:0];
            dbus_wdata = {4{mem_rt_data[7:0]}};
        end else if (is_half) begin
            dbus_sel   = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
            dbus_wdata = {2{mem_rt_data[15:0]}};
        end else if (is_word) begin
            dbus_sel   = 4'b1111;
        end
    end

    always_comb begin
        stallreq_mem = busy;
        out_waddr    = mem_waddr;
        out_we       = mem_we & ~busy & ~misalign;
        out_wdata    = mem_wdata;
        if (state_cur == DONE && is_load)
            out_wdata = rdata_q;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed loads/stores with varied ack latency, pass-through, reset and misalignment.
module tb_mem_lsu;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_waddr, out_waddr;
    logic        mem_we, out_we;
    logic [31:0] mem_wdata, out_wdata, mem_mem_addr, mem_rt_data;
    logic [7:0]  mem_mem_aluop;
    logic        stallreq_mem, dbus_req, dbus_we, dbus_ack, misalign_exc;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_sel;

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  waddr;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_mem_addr(mem_mem_addr), .mem_mem_aluop(mem_mem_aluop), .mem_rt_data(mem_rt_data),
        .out_waddr(out_waddr), .out_we(out_we), .out_wdata(out_wdata),
        .stallreq_mem(stallreq_mem), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .misalign_exc(misalign_exc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] wdata, input logic we, input logic [4:0] waddr);
        mem_mem_aluop = op;
        mem_mem_addr  = addr;
        mem_rt_data   = rt;
        mem_wdata     = wdata;
        mem_we        = we;
        mem_waddr     = waddr;
    endtask

    task automatic nop();
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Called just after a rising edge; returns just after the edge following DONE.
    task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] wdata, input logic we,
                          input logic [31:0] rdata, input int wait_n,
                          input logic [3:0] exp_sel, input logic exp_bus_we,
                          input logic [31:0] exp_bus_wdata, input logic [31:0] exp_out);
        exp_t e;
        int   stalls = 0;
        bit   done = 0;
        drive(op, addr, rt, wdata, we, 5'd9);
        sb.push_back('{wdata: exp_out, we: we, waddr: 5'd9, stalls: wait_n + 1});
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stallreq_mem) begin
                if (stalls == 0) begin
                    check({name, " req"},   dbus_req, 1);
                    check({name, " addr"},  dbus_addr, {addr[31:2], 2'b00});
                    check({name, " sel"},   dbus_sel, exp_sel);
                    check({name, " buswe"}, dbus_we, exp_bus_we);
                    if (exp_bus_we) check({name, " buswdata"}, dbus_wdata, exp_bus_wdata);
                end
                check({name, " stall_we"}, out_we, 0);
                dbus_rdata = rdata;
                dbus_ack   = (stalls == wait_n);
                stalls++;
                @(posedge clk); #1;
                dbus_ack   = 1'b0;
                dbus_rdata = ~rdata;
            end else begin
                e = sb.pop_front();
                check({name, " stalls"},    stalls, e.stalls);
                check({name, " out_wdata"}, out_wdata, e.wdata);
                check({name, " out_we"},    out_we, e.we);
                check({name, " out_waddr"}, out_waddr, e.waddr);
                check({name, " done_req"},  dbus_req, 0);
                done = 1;
            end
        end
        check({name, " timeout"}, done, 1);
        @(posedge clk); #1;
        nop();
    endtask

    initial begin
        rst = 1'b1;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;
        nop();
        @(negedge clk);
        check("rst stall", stallreq_mem, 0);
        check("rst req", dbus_req, 0);
        check("rst misalign", misalign_exc, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst rdata_q", dut.rdata_q, 0);

        drive(OP_ADD, 32'h0, 32'h0, 32'h5, 1'b1, 5'd3);
        @(negedge clk);
        check("add out_wdata", out_wdata, 32'h5);
        check("add out_we", out_we, 1);
        check("add out_waddr", out_waddr, 3);
        check("add stall", stallreq_mem, 0);
        check("add req", dbus_req, 0);
        @(posedge clk); #1;

        run_op("lw",  OP_LW,  32'h100, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 0, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
        run_op("lb",  OP_LB,  32'h103, 32'h0, 32'h0, 1'b1, 32'h80FFFFFF, 3, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80);
        run_op("lbu", OP_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 32'h80FFFFFF, 3, 4'b1000, 1'b0, 32'h0, 32'h00000080);
        run_op("lh",  OP_LH,  32'h100, 32'h0, 32'h0, 1'b1, 32'h00008001, 1, 4'b0011, 1'b0, 32'h0, 32'hFFFF8001);
        run_op("lhu", OP_LHU, 32'h102, 32'h0, 32'h0, 1'b1, 32'h80011234, 0, 4'b1100, 1'b0, 32'h0, 32'h00008001);
        run_op("sh",  OP_SH,  32'h202, 32'h1234ABCD, 32'h202, 1'b0, 32'h0, 0, 4'b1100, 1'b1, 32'hABCDABCD, 32'h202);
        run_op("sb",  OP_SB,  32'h101, 32'h000000AB, 32'h101, 1'b0, 32'h0, 2, 4'b0010, 1'b1, 32'hABABABAB, 32'h101);
        run_op("sw",  OP_SW,  32'h104, 32'hCAFEF00D, 32'h104, 1'b0, 32'h0, 1, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h104);

        // Reset taken mid-WAIT, followed by a late ack that must be ignored.
        drive(OP_LW, 32'h300, 32'h0, 32'h0, 1'b1, 5'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw waiting", stallreq_mem, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstw during we", out_we, 0);
        check("rstw during misalign", misalign_exc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nop();
        dbus_ack = 1'b1;
        dbus_rdata = 32'h12345678;
        @(negedge clk);
        check("rstw late stall", stallreq_mem, 0);
        check("rstw late we", out_we, 0);
        check("rstw rdata_q", dut.rdata_q, 0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rstw idle stall", stallreq_mem, 0);
        check("rstw rdata_q2", dut.rdata_q, 0);
        @(posedge clk); #1;

`ifdef LSU_MISALIGN_TRAP_EN
        drive(OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 5'd4);
        @(negedge clk);
        check("mis exc", misalign_exc, 1);
        check("mis req", dbus_req, 0);
        check("mis stall", stallreq_mem, 0);
        check("mis we", out_we, 0);
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        check("mis idle", stallreq_mem, 0);
        @(posedge clk); #1;
`else
        drive(OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 5'd4);
        @(negedge clk);
        check("mis exc0", misalign_exc, 0);
        @(posedge clk); #1;
        run_op("lwmis", OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 32'h11223344, 0, 4'b1111, 1'b0, 32'h0, 32'h11223344);
`endif

        check("sb empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
